usb_phy_tx: RTL and testbench

//  Full-speed USB serial transmitter driving the ctrl-side dp_tx/dn_tx/tx_oen of the frontend interface.

---
 rtl/usb_phy_tx_pkg.sv | 25 ++
 rtl/usb_phy_tx_if.sv | 38 +++
 rtl/usb_phy_tx_nrzi.sv | 43 ++++
 rtl/usb_phy_tx.sv | 192 +++++++++++++++++++
 tb/tb_usb_phy_tx.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/usb_phy_tx_pkg.sv
// Shared types and constants for the full-speed USB serial transmitter.
// Optional abort support is selected with USB_TX_ABORT_EN.
package usb_phy_tx_pkg;

    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_K   = 2'b01,
        LS_J   = 2'b10
    } line_state_e;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam logic [7:0] SYNC_PATTERN = 8'h80;
    localparam int         STUFF_LEN    = 6;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SYNC    = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_EOP_SE0 = 3'd3;
    localparam logic [2:0] ST_EOP_J   = 3'd4;
    localparam logic [2:0] ST_ABORT   = 3'd5;

endpackage

// File: rtl/usb_phy_tx_if.sv
// Packet-byte stream plus line drive signals of the USB transmitter.
// The tx_abort signal exists only when USB_TX_ABORT_EN is defined.
interface usb_phy_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_underrun;
    logic       dp_tx;
    logic       dn_tx;
    logic       tx_oen;
`ifdef USB_TX_ABORT_EN
    logic       tx_abort;

    modport master (
        output tx_data, tx_valid, tx_last, tx_abort,
        input  tx_ready, tx_busy, tx_underrun, dp_tx, dn_tx, tx_oen
    );

    modport slave (
        input  tx_data, tx_valid, tx_last, tx_abort,
        output tx_ready, tx_busy, tx_underrun, dp_tx, dn_tx, tx_oen
    );
`else
    modport master (
        output tx_data, tx_valid, tx_last,
        input  tx_ready, tx_busy, tx_underrun, dp_tx, dn_tx, tx_oen
    );

    modport slave (
        input  tx_data, tx_valid, tx_last,
        output tx_ready, tx_busy, tx_underrun, dp_tx, dn_tx, tx_oen
    );
`endif

endinterface

// File: rtl/usb_phy_tx_nrzi.sv
// NRZI line encoder: on each bit strobe registers the next D+/D- value.
// Raw 0 toggles J/K, raw 1 holds; SE0 and forced J override the data path.
module usb_tx_nrzi
    import usb_phy_tx_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_stb,
    input  logic i_bit,
    input  logic i_se0,
    input  logic i_force_j,
    output logic o_dp,
    output logic o_dn
);

    line_state_e r_line;
    logic        r_lvl_k;
    logic        w_next_k;

    // SE0 leaves the differential level untouched so data could resume from it.
    assign w_next_k = i_bit ? r_lvl_k : ~r_lvl_k;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_line  <= LS_J;
            r_lvl_k <= 1'b0;
        end else if (i_stb) begin
            if (i_force_j) begin
                r_line  <= LS_J;
                r_lvl_k <= 1'b0;
            end else if (i_se0) begin
                r_line  <= LS_SE0;
            end else begin
                r_lvl_k <= w_next_k;
                r_line  <= w_next_k ? LS_K : LS_J;
            end
        end
    end

    assign o_dp = r_line[1];
    assign o_dn = r_line[0];

endmodule

// File: rtl/usb_phy_tx.sv
// Full-speed USB transmitter: SYNC, LSB-first bit-stuffed NRZI data, EOP.
// Defining USB_TX_ABORT_EN adds tx_abort (forced stuff error, then EOP).
module usb_phy_tx
    import usb_phy_tx_pkg::*;
#(
    parameter int CLK_PER_BIT = 4
)
(
    input  logic        clk,
    input  logic        rst_n,
    usb_phy_tx_if.slave tx
);

    localparam int            CW       = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(CLK_PER_BIT - 1);

    logic [2:0]    r_state;
    logic [CW-1:0] r_bit_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_last;
    logic [2:0]    r_ones;

    logic       w_bit_end;
    logic       w_in_frame;
    logic       w_need_stuff;
    logic       w_byte_done;
    logic       w_abort;
    logic       w_load;
    logic       w_take;
    logic [2:0] w_idx_nxt;
    logic       w_stb;
    logic       w_bit;
    logic       w_se0;
    logic       w_force_j;

    assign w_bit_end    = (r_bit_cnt == BIT_LAST);
    assign w_in_frame   = (r_state == ST_SYNC) || (r_state == ST_DATA);
    assign w_need_stuff = (r_state == ST_DATA) && (r_ones == 3'(STUFF_LEN));
    assign w_byte_done  = (r_bit_idx == 3'd7) && !w_need_stuff;
    assign w_idx_nxt    = r_bit_idx + 3'd1;

    // Load slot: final clock of the SYNC byte or of a non-final data byte.
    assign w_load = w_bit_end && w_byte_done && !w_abort &&
                    ((r_state == ST_SYNC) || ((r_state == ST_DATA) && !r_last));
    assign w_take = w_load && tx.tx_valid;

    assign tx.tx_ready    = w_take;
    assign tx.tx_underrun = w_load && !tx.tx_valid;
    assign tx.tx_oen      = (r_state != ST_IDLE);
    assign tx.tx_busy     = (r_state != ST_IDLE);

`ifdef USB_TX_ABORT_EN
    logic r_abort_req;

    assign w_abort = w_in_frame && (r_abort_req || tx.tx_abort);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_abort_req <= 1'b0;
        end else begin
            r_abort_req <= w_abort;
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    // Decide what the next bit period carries; applied at the edge that starts it.
    always_comb begin
        w_stb     = 1'b0;
        w_bit     = 1'b1;
        w_se0     = 1'b0;
        w_force_j = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stb = tx.tx_valid;
                w_bit = SYNC_PATTERN[0];
            end
            ST_SYNC, ST_DATA: begin
                w_stb = w_bit_end;
                if (w_abort) begin
                    w_bit = 1'b1;
                end else if (w_need_stuff) begin
                    w_bit = 1'b0;
                end else if (!w_byte_done) begin
                    w_bit = (r_state == ST_SYNC) ? SYNC_PATTERN[w_idx_nxt] : r_shift[w_idx_nxt];
                end else if (w_take) begin
                    w_bit = tx.tx_data[0];
                end else begin
                    w_se0 = 1'b1;
                end
            end
            ST_EOP_SE0: begin
                w_stb     = w_bit_end && (r_bit_idx == 3'd1);
                w_force_j = 1'b1;
            end
            ST_ABORT: begin
                w_stb = w_bit_end;
                w_se0 = (r_bit_idx == 3'd6);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_last    <= 1'b0;
            r_ones    <= 3'd0;
        end else begin
            r_bit_cnt <= ((r_state == ST_IDLE) || w_bit_end) ? '0 : r_bit_cnt + CW'(1);

            // The ones run covers SYNC too, so its closing 1 counts toward stuffing.
            if (w_stb && !w_se0 && !w_abort && ((r_state == ST_IDLE) || w_in_frame)) begin
                r_ones <= w_bit ? r_ones + 3'd1 : 3'd0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (tx.tx_valid) begin
                        r_state   <= ST_SYNC;
                        r_bit_idx <= 3'd0;
                    end
                end
                ST_SYNC, ST_DATA: begin
                    if (w_bit_end) begin
                        if (w_abort) begin
                            r_state   <= ST_ABORT;
                            r_bit_idx <= 3'd0;
                        end else if (w_need_stuff) begin
                            r_bit_idx <= r_bit_idx;
                        end else if (!w_byte_done) begin
                            r_bit_idx <= w_idx_nxt;
                        end else if (w_take) begin
                            r_state   <= ST_DATA;
                            r_shift   <= tx.tx_data;
                            r_last    <= tx.tx_last;
                            r_bit_idx <= 3'd0;
                        end else begin
                            r_state   <= ST_EOP_SE0;
                            r_bit_idx <= 3'd0;
                        end
                    end
                end
                ST_EOP_SE0: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd1) begin
                            r_state <= ST_EOP_J;
                        end else begin
                            r_bit_idx <= w_idx_nxt;
                        end
                    end
                end
                ST_EOP_J: begin
                    if (w_bit_end) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ABORT: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd6) begin
                            r_state   <= ST_EOP_SE0;
                            r_bit_idx <= 3'd0;
                        end else begin
                            r_bit_idx <= w_idx_nxt;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    usb_tx_nrzi u_nrzi (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_stb     (w_stb),
        .i_bit     (w_bit),
        .i_se0     (w_se0),
        .i_force_j (w_force_j),
        .o_dp      (tx.dp_tx),
        .o_dn      (tx.dn_tx)
    );

endmodule

// File: tb/tb_usb_phy_tx.sv
// Directed packet vectors for usb_phy_tx: line symbols per bit period, handshake counts.
// Adds an abort vector when USB_TX_ABORT_EN is defined.
module tb_usb_phy_tx;
    import usb_phy_tx_pkg::*;

    typedef struct {
        int         nbytes;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         drop_at;
        int         abort_at;
        int         exp_ready;
        int         exp_under;
        int         exp_gap;
    } vec_t;

`ifdef USB_TX_ABORT_EN
    localparam int NV = 7;
`else
    localparam int NV = 6;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    vec_t  vecs [NV];
    string exp_line [NV];

    always #5 clk = ~clk;

    usb_phy_tx_if tx_if ();

    usb_phy_tx #(.CLK_PER_BIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tx    (tx_if.slave)
    );

    function automatic byte sym(input logic dp, input logic dn);
        case ({dp, dn})
            2'b10:   return 8'h4A;
            2'b01:   return 8'h4B;
            2'b00:   return 8'h30;
            default: return 8'h58;
        endcase
    endfunction

    function automatic logic [7:0] pick(input int v, input int i);
        case (i)
            0:       return vecs[v].b0;
            1:       return vecs[v].b1;
            default: return vecs[v].b2;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int v, input int bi);
        if (bi < vecs[v].nbytes && !(vecs[v].drop_at > 0 && bi >= vecs[v].drop_at)) begin
            tx_if.tx_valid = 1'b1;
            tx_if.tx_data  = pick(v, bi);
            tx_if.tx_last  = (bi == vecs[v].nbytes - 1);
        end else begin
            tx_if.tx_valid = 1'b0;
            tx_if.tx_last  = 1'b0;
        end
    endtask

    task automatic run_vec(input int v);
        string clocks;
        string periods;
        int    bi, nready, nunder, r1, r2, busy_bad;
        bit    started, done, abort_done;
        byte   c;
        clocks = "";
        periods = "";
        bi = 0; nready = 0; nunder = 0; r1 = -1; r2 = -1; busy_bad = 0;
        started = 1'b0; done = 1'b0; abort_done = 1'b0;
        @(posedge clk); #1;
        drive(v, bi);
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            if (tx_if.tx_oen) begin
                started = 1'b1;
                clocks = $sformatf("%s%c", clocks, sym(tx_if.dp_tx, tx_if.dn_tx));
            end else if (started) begin
                done = 1'b1;
                break;
            end
            if (tx_if.tx_busy !== tx_if.tx_oen) busy_bad++;
            if (tx_if.tx_underrun) nunder++;
            if (tx_if.tx_ready) begin
                nready++;
                if (r1 < 0) r1 = clocks.len();
                else if (r2 < 0) r2 = clocks.len();
                bi++;
            end
            @(posedge clk); #1;
            drive(v, bi);
`ifdef USB_TX_ABORT_EN
            if (vecs[v].abort_at != 0 && nready == vecs[v].abort_at && !abort_done) begin
                tx_if.tx_abort = 1'b1;
                abort_done = 1'b1;
            end else begin
                tx_if.tx_abort = 1'b0;
            end
`endif
        end
        tx_if.tx_valid = 1'b0;
        check($sformatf("v%0d_done", v), int'(done), 1);
        for (int i = 0; i + 3 < clocks.len(); i += 4) begin
            c = clocks[i];
            if (clocks[i+1] != c || clocks[i+2] != c || clocks[i+3] != c) c = 8'h3F;
            periods = $sformatf("%s%c", periods, c);
        end
        n_vec++;
        if (periods != exp_line[v] || clocks.len() != 4 * exp_line[v].len()) begin
            n_err++;
            $display("FAIL v%0d_line: got %s (%0d clk) expected %s", v, periods, clocks.len(), exp_line[v]);
        end
        check($sformatf("v%0d_ready", v), nready, vecs[v].exp_ready);
        check($sformatf("v%0d_underrun", v), nunder, vecs[v].exp_under);
        check($sformatf("v%0d_busy_vs_oen", v), busy_bad, 0);
        check($sformatf("v%0d_idle_line", v), {30'd0, tx_if.dp_tx, tx_if.dn_tx}, 2);
        if (vecs[v].exp_gap > 0) check($sformatf("v%0d_ready_gap", v), r2 - r1, vecs[v].exp_gap);
    endtask

    initial begin
        int  cyc;
        bit  se0_seen;
        bit  rdy;
        byte s45;

        vecs[0] = '{1, 8'hC3, 8'h00, 8'h00, 0, 0, 1, 0, 0};
        exp_line[0] = "KJKJKJKKKKJKJKKK00J";
        vecs[1] = '{2, 8'hFF, 8'h01, 8'h00, 0, 0, 2, 0, 36};
        exp_line[1] = "KJKJKJKKKKKKKJJJJJKJKJKJK00J";
        vecs[2] = '{1, 8'h3F, 8'h00, 8'h00, 0, 0, 1, 0, 0};
        exp_line[2] = "KJKJKJKKKKKKKJJKJ00J";
        vecs[3] = '{1, 8'hFC, 8'h00, 8'h00, 0, 0, 1, 0, 0};
        exp_line[3] = "KJKJKJKKJKKKKKKKJ00J";
        vecs[4] = '{3, 8'h00, 8'h55, 8'hAA, 1, 0, 1, 1, 0};
        exp_line[4] = "KJKJKJKKJKJKJKJK00J";
        vecs[5] = '{2, 8'hA5, 8'h5A, 8'h00, 0, 0, 2, 0, 32};
        exp_line[5] = "KJKJKJKKKJJKJJKKJJKKKJJK00J";
`ifdef USB_TX_ABORT_EN
        vecs[6] = '{3, 8'hA5, 8'h5A, 8'h00, 0, 2, 2, 0, 0};
        exp_line[6] = "KJKJKJKKKJJKJJKKJJJJJJJJ00J";
        tx_if.tx_abort = 1'b0;
`endif
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'h00;
        tx_if.tx_last  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dp", int'(tx_if.dp_tx), 1);
        check("rst_dn", int'(tx_if.dn_tx), 0);
        check("rst_oen", int'(tx_if.tx_oen), 0);
        check("rst_busy", int'(tx_if.tx_busy), 0);
        check("rst_ready", int'(tx_if.tx_ready), 0);
        check("rst_underrun", int'(tx_if.tx_underrun), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int v = 0; v < NV; v++) run_vec(v);

        // Reset asserted in the middle of data bit 3 of a single-byte packet.
        @(posedge clk); #1;
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = 8'hC3;
        tx_if.tx_last  = 1'b1;
        cyc = -1;
        se0_seen = 1'b0;
        s45 = 8'h00;
        for (int t = 0; t < 200 && cyc < 45; t++) begin
            @(negedge clk);
            if (tx_if.tx_oen) cyc++;
            if (cyc >= 0 && !tx_if.dp_tx && !tx_if.dn_tx) se0_seen = 1'b1;
            s45 = sym(tx_if.dp_tx, tx_if.dn_tx);
            rdy = tx_if.tx_ready;
            if (cyc < 45) begin
                @(posedge clk); #1;
                if (rdy) tx_if.tx_valid = 1'b0;
            end
        end
        check("mid_reached_bit3", cyc, 45);
        check("mid_bit3_line", int'(s45), int'(8'h4B));
        tx_if.tx_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_dp", int'(tx_if.dp_tx), 1);
        check("mid_rst_dn", int'(tx_if.dn_tx), 0);
        check("mid_rst_oen", int'(tx_if.tx_oen), 0);
        check("mid_rst_busy", int'(tx_if.tx_busy), 0);
        repeat (2) begin
            @(negedge clk);
            if (!tx_if.dp_tx && !tx_if.dn_tx) se0_seen = 1'b1;
        end
        check("mid_no_se0", int'(se0_seen), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run_vec(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
